// File: rtl/rr_chan_mux.sv
// rtl/rr_chan_mux.sv - N-channel registered mux with fixed-select or round-robin arbitration
// One-entry output register; in_ready is a same-cycle grant so a full register can drain and refill every cycle.

module rr_chan_mux #(
  parameter int N  = 8,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_ch,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic [SW-1:0] out_ch_q, out_ch_d;
  logic          out_valid_q, out_valid_d;

  logic          ld;
  logic          gnt_vld;
  logic [SW-1:0] gnt;
  logic [W-1:0]  gnt_data;
  logic          xfer;

  // Round-robin search: rotate the request vector so bit 0 is the channel at ptr.
  logic [2*N-1:0] req_rot;
  logic [SW:0]    rr_sum;

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    req_rot = '0;
    rr_sum  = '0;
    if (!mode) begin
      if ({1'b0, sel} < (SW+1)'(N)) begin
        if (in_valid[sel]) begin
          gnt_vld = 1'b1;
          gnt     = sel;
        end
      end
    end else begin
      req_rot = {in_valid, in_valid} >> ptr_q;
      for (int k = N - 1; k >= 0; k--) begin
        if (req_rot[k]) begin
          gnt_vld = 1'b1;
          rr_sum  = {1'b0, ptr_q} + (SW+1)'(k);
        end
      end
      // Explicit wrap at N keeps non-power-of-2 channel counts correct.
      if (rr_sum >= (SW+1)'(N)) begin
        rr_sum = rr_sum - (SW+1)'(N);
      end
      gnt = rr_sum[SW-1:0];
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt == SW'(i)) begin
        gnt_data = in_data[i*W +: W];
      end
    end
  end

  assign ld   = !out_valid_q || out_ready;
  assign xfer = ld && gnt_vld && !rst;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready = N'(1) << gnt;
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (ld) begin
      if (gnt_vld) begin
        out_data_d  = gnt_data;
        out_ch_d    = gnt;
        out_valid_d = 1'b1;
        if (mode) begin
          ptr_d = (gnt == SW'(N - 1)) ? '0 : gnt + SW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_chan_mux.sv
// tb/tb_rr_chan_mux.sv - self-checking bench for rr_chan_mux
// Table vectors, directed corner sequences and random traffic against a behavioural model.

module tb_rr_chan_mux;

  localparam int N  = 8;
  localparam int W  = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [SW-1:0]  sel;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_ch;
  logic           out_valid;
  logic           out_ready;

  rr_chan_mux #(.N(N), .W(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic          m_ov;
  logic [W-1:0]  m_od;
  logic [SW-1:0] m_ch;
  int            m_ptr;
  logic [N-1:0]  last_rdy;

  typedef struct {
    logic [N*W-1:0] d;
    logic [N-1:0]   v;
    logic           md;
    logic [SW-1:0]  s;
    logic           ordy;
    logic [N-1:0]   exp_rdy;
    logic           exp_ov;
    logic [W-1:0]   exp_od;
    logic [SW-1:0]  exp_ch;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Channel the rules grant this cycle, or -1 for none.
  function automatic int model_gnt(input logic [N-1:0] v, input logic md,
                                   input logic [SW-1:0] s, input int ptr);
    if (!md) return (int'(s) < N && v[s]) ? int'(s) : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (ptr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ov = 1'b0; m_od = '0; m_ch = '0; m_ptr = 0;
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic apply(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic md,
                       input logic [SW-1:0] s, input logic ordy);
    int g;
    logic ld;
    logic [N-1:0] er;
    in_data = d; in_valid = v; mode = md; sel = s; out_ready = ordy;
    #1;
    ld = !m_ov || ordy;
    g  = model_gnt(v, md, s, m_ptr);
    er = (ld && g >= 0) ? (N'(1) << g) : '0;
    last_rdy = in_ready;
    chk("in_ready", 64'(in_ready), 64'(er));
    @(posedge clk);
    if (ld) begin
      if (g >= 0) begin
        m_ov = 1'b1;
        m_od = d[g*W +: W];
        m_ch = g[SW-1:0];
        if (md) m_ptr = (g == N - 1) ? 0 : g + 1;
      end else begin
        m_ov = 1'b0;
      end
    end
    #1;
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("out_ch", 64'(out_ch), 64'(m_ch));
    @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] rand_data();
    logic [N*W-1:0] r;
    r = {$urandom, $urandom};
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] sweep;
    logic [N*W-1:0] rd;
    logic [W-1:0]   held;

    for (int i = 0; i < N; i++) sweep[i*W +: W] = W'(8'h10 + i);
    for (int i = 0; i < N; i++) begin
      tbl[i] = '{d: sweep, v: 8'hFF, md: 1'b0, s: SW'(i), ordy: 1'b1,
                 exp_rdy: N'(1) << i, exp_ov: 1'b1, exp_od: W'(8'h10 + i), exp_ch: SW'(i)};
    end
    tbl[8] = '{d: sweep, v: 8'hF7, md: 1'b0, s: 3'd3, ordy: 1'b1,
               exp_rdy: 8'h00, exp_ov: 1'b0, exp_od: 8'h17, exp_ch: 3'd7};
    tbl[9] = '{d: sweep, v: 8'hFF, md: 1'b0, s: 3'd3, ordy: 1'b1,
               exp_rdy: 8'h08, exp_ov: 1'b1, exp_od: 8'h13, exp_ch: 3'd3};

    rst = 1'b1; in_data = '0; in_valid = 8'hFF; mode = 1'b0; sel = '0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ch", 64'(out_ch), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;

    // Asynchronous reset mid-cycle while holding 8'hA5.
    rd = '0; rd[7:0] = 8'hA5; rd[15:8] = 8'h5A;
    apply(rd, 8'h01, 1'b0, 3'd0, 1'b1);
    chk("pre_rst_data", 64'(out_data), 64'hA5);
    in_valid = 8'h02; sel = 3'd1; out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_data", 64'(out_data), 64'd0);
    chk("arst_out_ch", 64'(out_ch), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("arst_in_ready_ordy", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("arst_hold_valid", 64'(out_valid), 64'd0);
    chk("arst_hold_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fixed-select sweep and an unrequested select.
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].d, tbl[i].v, tbl[i].md, tbl[i].s, tbl[i].ordy);
      chk($sformatf("tbl%0d_rdy", i), 64'(last_rdy), 64'(tbl[i].exp_rdy));
      chk($sformatf("tbl%0d_ov", i), 64'(out_valid), 64'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_od", i), 64'(out_data), 64'(tbl[i].exp_od));
      chk($sformatf("tbl%0d_ch", i), 64'(out_ch), 64'(tbl[i].exp_ch));
    end

    // Round-robin fairness; pointer is still 0 since only mode 0 ran.
    for (int i = 0; i < 16; i++) begin
      apply(rand_data(), 8'hFF, 1'b1, 3'd0, 1'b1);
      chk("rr_all_ch", 64'(out_ch), 64'(i % 8));
    end
    for (int i = 0; i < 6; i++) begin
      int e[3] = '{0, 2, 7};
      apply(rand_data(), 8'b1000_0101, 1'b1, 3'd0, 1'b1);
      chk("rr_sparse_ch", 64'(out_ch), 64'(e[i % 3]));
    end

    // Backpressure with the register holding channel 2.
    apply(rand_data(), 8'h04, 1'b1, 3'd0, 1'b1);
    chk("bp_load_ch", 64'(out_ch), 64'd2);
    held = out_data;
    for (int i = 0; i < 4; i++) begin
      apply(rand_data(), 8'hFF, 1'b1, 3'd0, 1'b0);
      chk("bp_rdy", 64'(last_rdy), 64'd0);
      chk("bp_ch", 64'(out_ch), 64'd2);
      chk("bp_data", 64'(out_data), 64'(held));
    end
    apply(rand_data(), 8'hFF, 1'b1, 3'd0, 1'b1);
    chk("bp_release_rdy", 64'(last_rdy), 64'h08);
    chk("bp_release_ch", 64'(out_ch), 64'd3);

    // Drain to empty, then refill from channel 5.
    held = out_data;
    apply(rand_data(), 8'h00, 1'b1, 3'd0, 1'b1);
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_data_hold", 64'(out_data), 64'(held));
    apply(rand_data(), 8'h20, 1'b1, 3'd0, 1'b0);
    chk("refill_rdy", 64'(last_rdy), 64'h20);
    chk("refill_ch", 64'(out_ch), 64'd5);

    // Mode switch must leave the RR pointer at 4.
    apply(rand_data(), 8'h08, 1'b1, 3'd0, 1'b1);
    chk("ms_ptr_setup_ch", 64'(out_ch), 64'd3);
    for (int i = 0; i < 3; i++) begin
      apply(rand_data(), 8'hFF, 1'b0, 3'd1, 1'b1);
      chk("ms_fixed_ch", 64'(out_ch), 64'd1);
    end
    apply(rand_data(), 8'hFF, 1'b1, 3'd1, 1'b1);
    chk("ms_rr_rdy", 64'(last_rdy), 64'h10);
    chk("ms_rr_ch", 64'(out_ch), 64'd4);

    for (int i = 0; i < 400; i++) begin
      apply(rand_data(), N'($urandom), 1'($urandom), SW'($urandom),
            ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_chan_mux.md
Name: rr_chan_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and a one-entry output register.
- Two selection modes: fixed (external select, like the structural 8:1 mux but registered) and round-robin (fair arbitration among requesting channels).
- Sits between multiple producer channels and one consumer.
- Reports which channel each output word came from.

Parameters:
- N, 8, number of input channels (N >= 2).
- W, 8, data width per channel.
- SW, $clog2(N), width of select/channel-index fields.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  N*W  packed channel data; channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SW  channel index used when mode = 0.
- out_data  output  W  registered output data.
- out_ch  output  SW  registered index of the source channel.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset: asynchronous, active-high. While rst = 1:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - RR pointer ptr = 0.
  - in_ready = all 0.
  - Reset mid-transfer discards the held word; no handshake completes in the reset cycle.
- States (implied by out_valid):
  - EMPTY (out_valid = 0).
  - FULL (out_valid = 1).
- Load enable: ld = EMPTY | (FULL & out_ready). This is a pass-through replace: a full register draining and refilling in the same cycle sustains 1 word/cycle.
- Grant, combinational, computed every cycle:
  - mode 0: gnt = sel if in_valid[sel] = 1; otherwise no grant. A sel value >= N means no grant.
  - mode 1: gnt = first i with in_valid[i] = 1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). No grant if in_valid = 0.
- in_ready[i] = ld & (gnt exists) & (gnt == i). At most one bit is set. An input transfer occurs when in_valid[i] & in_ready[i].
- On transfer: out_data <= in_data[gnt], out_ch <= gnt, out_valid <= 1. Latency 1 cycle from transfer to out_valid.
- FULL & out_ready with no grant: out_valid <= 0 (go EMPTY). out_data and out_ch hold their last values.
- FULL & !out_ready: hold out_data, out_ch and out_valid unchanged; all in_ready = 0 (backpressure).
- RR pointer:
  - Updates only on a transfer in mode 1: ptr <= (gnt == N-1) ? 0 : gnt+1.
  - Unchanged in mode 0 and on cycles without a transfer.
- Mode or sel changes:
  - Take effect on the same-cycle grant.
  - Never alter a word already in the register.
- Upstream rule: producers must hold in_data and in_valid until their ready is seen. The block does not register inputs.
- No combinational path from out_ready to out_data. in_ready does depend combinationally on out_ready, in_valid, mode and sel.
- Width rules:
  - out_ch is the zero-extended index.
  - For non-power-of-2 N, the pointer wraps explicitly at N-1, not by modulo 2^SW.

Test Plan:
- Reset/idle: assert rst asynchronously mid-cycle while FULL (out_data = 8'hA5) -> out_valid, out_data and out_ch drop to 0 immediately; in_ready = 0 throughout reset.
- Fixed-select sweep: mode = 0, in_data channel i = 8'h10+i, all valid, out_ready = 1, sel stepped 0..7 once per cycle -> out_data = 8'h10..8'h17 and out_ch = 0..7, each 1 cycle after its sel; sel = 3 with in_valid[3] = 0 -> no transfer, out_valid = 0 next cycle.
- Round-robin fairness: mode = 1, in_valid = 8'hFF, out_ready = 1 for 16 cycles -> out_ch sequence 0,1,...,7,0,...,7 at one word per cycle; with in_valid = 8'b1000_0101 -> sequence 0,2,7,0,2,7.
- Backpressure: mode = 1, FULL with out_ch = 2, out_ready = 0 for 4 cycles -> out_data and out_ch stable, in_ready = 0, ptr stays 3; out_ready = 1 -> next word from channel 3 (if valid) loads in that same cycle.
- Drain to empty: FULL, out_ready = 1, in_valid = 0 -> out_valid = 0 next cycle, out_data holds; then in_valid[5] = 1 -> in_ready[5] = 1 immediately, out_ch = 5 next cycle.
- Mode switch: RR running with ptr = 4, switch to mode = 0, sel = 1 for 3 transfers, then back to mode = 1 -> the three words come from ch 1, ptr remains 4, and the next RR grant searches from ch 4.
